// File: rtl/execute_feedback_gather_if.sv
// Bundle of per-unit execute feedback channels and the flattened pack produced from them.
// Groups with a zero unit count keep a single spare slot that is never read.
interface execute_feedback_gather_if #(
    parameter int ALU_UNIT_NUM     = 2,
    parameter int BRU_UNIT_NUM     = 1,
    parameter int CSR_UNIT_NUM     = 1,
    parameter int DIV_UNIT_NUM     = 1,
    parameter int LSU_UNIT_NUM     = 1,
    parameter int MUL_UNIT_NUM     = 2,
    parameter int EXECUTE_UNIT_NUM = ALU_UNIT_NUM + BRU_UNIT_NUM + CSR_UNIT_NUM +
                                     DIV_UNIT_NUM + LSU_UNIT_NUM + MUL_UNIT_NUM,
    parameter int PHY_REG_ID_WIDTH = 6
);
    localparam int ALU_ARR  = (ALU_UNIT_NUM > 0) ? ALU_UNIT_NUM : 1;
    localparam int BRU_ARR  = (BRU_UNIT_NUM > 0) ? BRU_UNIT_NUM : 1;
    localparam int CSR_ARR  = (CSR_UNIT_NUM > 0) ? CSR_UNIT_NUM : 1;
    localparam int DIV_ARR  = (DIV_UNIT_NUM > 0) ? DIV_UNIT_NUM : 1;
    localparam int LSU_ARR  = (LSU_UNIT_NUM > 0) ? LSU_UNIT_NUM : 1;
    localparam int MUL_ARR  = (MUL_UNIT_NUM > 0) ? MUL_UNIT_NUM : 1;
    localparam int EXEC_ARR = (EXECUTE_UNIT_NUM > 0) ? EXECUTE_UNIT_NUM : 1;

    typedef struct packed {
        logic                        enable;
        logic [PHY_REG_ID_WIDTH-1:0] phy_id;
        logic [31:0]                 value;
    } channel_t;

    channel_t [0:ALU_ARR-1]  alu_execute_channel_feedback_pack;
    channel_t [0:BRU_ARR-1]  bru_execute_channel_feedback_pack;
    channel_t [0:CSR_ARR-1]  csr_execute_channel_feedback_pack;
    channel_t [0:DIV_ARR-1]  div_execute_channel_feedback_pack;
    channel_t [0:LSU_ARR-1]  lsu_execute_channel_feedback_pack;
    channel_t [0:MUL_ARR-1]  mul_execute_channel_feedback_pack;
    channel_t [0:EXEC_ARR-1] execute_feedback_pack;

    modport master (
        output alu_execute_channel_feedback_pack,
        output bru_execute_channel_feedback_pack,
        output csr_execute_channel_feedback_pack,
        output div_execute_channel_feedback_pack,
        output lsu_execute_channel_feedback_pack,
        output mul_execute_channel_feedback_pack,
        input  execute_feedback_pack
    );

    modport slave (
        input  alu_execute_channel_feedback_pack,
        input  bru_execute_channel_feedback_pack,
        input  csr_execute_channel_feedback_pack,
        input  div_execute_channel_feedback_pack,
        input  lsu_execute_channel_feedback_pack,
        input  mul_execute_channel_feedback_pack,
        output execute_feedback_pack
    );
endinterface

// File: rtl/execute_feedback_gather.sv
// Flattens ALU/BRU/CSR/DIV/LSU/MUL feedback into one pack indexed by global unit number,
// with an optional output register stage.
module execute_feedback_gather #(
    parameter int ALU_UNIT_NUM     = 2,
    parameter int BRU_UNIT_NUM     = 1,
    parameter int CSR_UNIT_NUM     = 1,
    parameter int DIV_UNIT_NUM     = 1,
    parameter int LSU_UNIT_NUM     = 1,
    parameter int MUL_UNIT_NUM     = 2,
    parameter int EXECUTE_UNIT_NUM = ALU_UNIT_NUM + BRU_UNIT_NUM + CSR_UNIT_NUM +
                                     DIV_UNIT_NUM + LSU_UNIT_NUM + MUL_UNIT_NUM,
    parameter int PHY_REG_ID_WIDTH = 6,
    parameter bit OUTPUT_REG       = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    execute_feedback_gather_if.slave fb
);
    localparam int CH_W    = 1 + PHY_REG_ID_WIDTH + 32;
    localparam int ALU_OFF = 0;
    localparam int BRU_OFF = ALU_OFF + ALU_UNIT_NUM;
    localparam int CSR_OFF = BRU_OFF + BRU_UNIT_NUM;
    localparam int DIV_OFF = CSR_OFF + CSR_UNIT_NUM;
    localparam int LSU_OFF = DIV_OFF + DIV_UNIT_NUM;
    localparam int MUL_OFF = LSU_OFF + LSU_UNIT_NUM;
    localparam int SUM_NUM = MUL_OFF + MUL_UNIT_NUM;

    if (EXECUTE_UNIT_NUM != SUM_NUM) begin : g_width_check
        $error("execute_feedback_gather: EXECUTE_UNIT_NUM must equal the sum of the unit counts");
    end

    logic [CH_W-1:0] pack_d [0:EXECUTE_UNIT_NUM-1];

    genvar gi;
    // Fixed concatenation order; a zero-count group generates nothing and later groups shift down.
    for (gi = 0; gi < ALU_UNIT_NUM; gi++) begin : g_alu
        assign pack_d[ALU_OFF + gi] = fb.alu_execute_channel_feedback_pack[gi];
    end
    for (gi = 0; gi < BRU_UNIT_NUM; gi++) begin : g_bru
        assign pack_d[BRU_OFF + gi] = fb.bru_execute_channel_feedback_pack[gi];
    end
    for (gi = 0; gi < CSR_UNIT_NUM; gi++) begin : g_csr
        assign pack_d[CSR_OFF + gi] = fb.csr_execute_channel_feedback_pack[gi];
    end
    for (gi = 0; gi < DIV_UNIT_NUM; gi++) begin : g_div
        assign pack_d[DIV_OFF + gi] = fb.div_execute_channel_feedback_pack[gi];
    end
    for (gi = 0; gi < LSU_UNIT_NUM; gi++) begin : g_lsu
        assign pack_d[LSU_OFF + gi] = fb.lsu_execute_channel_feedback_pack[gi];
    end
    for (gi = 0; gi < MUL_UNIT_NUM; gi++) begin : g_mul
        assign pack_d[MUL_OFF + gi] = fb.mul_execute_channel_feedback_pack[gi];
    end

    if (OUTPUT_REG) begin : g_reg
        logic [CH_W-1:0] pack_q [0:EXECUTE_UNIT_NUM-1];
        for (gi = 0; gi < EXECUTE_UNIT_NUM; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    pack_q[gi] <= '0;
                end else begin
                    pack_q[gi] <= pack_d[gi];
                end
            end
            assign fb.execute_feedback_pack[gi] = pack_q[gi];
        end
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};
        for (gi = 0; gi < EXECUTE_UNIT_NUM; gi++) begin : g_ch
            assign fb.execute_feedback_pack[gi] = pack_d[gi];
        end
    end
endmodule

// File: tb/tb_execute_feedback_gather.sv
// Scoreboard bench for execute_feedback_gather: default combinational build, zero-CSR build
// and registered build.
module tb_execute_feedback_gather;
    typedef logic [38:0] ch_bits_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ch_bits_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    execute_feedback_gather_if if_comb ();
    execute_feedback_gather_if #(.CSR_UNIT_NUM(0), .EXECUTE_UNIT_NUM(7)) if_zero ();
    execute_feedback_gather_if if_reg ();

    execute_feedback_gather u_comb (.clk(clk), .rst(rst), .fb(if_comb.slave));
    execute_feedback_gather #(.CSR_UNIT_NUM(0), .EXECUTE_UNIT_NUM(7)) u_zero (
        .clk(clk), .rst(rst), .fb(if_zero.slave));
    execute_feedback_gather #(.OUTPUT_REG(1'b1)) u_reg (.clk(clk), .rst(rst), .fb(if_reg.slave));

    function automatic ch_bits_t mk(input logic en, input logic [5:0] phy, input logic [31:0] val);
        return {en, phy, val};
    endfunction

    function automatic ch_bits_t rnd_ch();
        return mk(1'($urandom_range(0, 1)), 6'($urandom), 32'($urandom));
    endfunction

    task automatic drive_comb(input ch_bits_t v[8]);
        if_comb.alu_execute_channel_feedback_pack[0] = v[0];
        if_comb.alu_execute_channel_feedback_pack[1] = v[1];
        if_comb.bru_execute_channel_feedback_pack[0] = v[2];
        if_comb.csr_execute_channel_feedback_pack[0] = v[3];
        if_comb.div_execute_channel_feedback_pack[0] = v[4];
        if_comb.lsu_execute_channel_feedback_pack[0] = v[5];
        if_comb.mul_execute_channel_feedback_pack[0] = v[6];
        if_comb.mul_execute_channel_feedback_pack[1] = v[7];
    endtask

    task automatic drive_reg(input ch_bits_t v[8]);
        if_reg.alu_execute_channel_feedback_pack[0] = v[0];
        if_reg.alu_execute_channel_feedback_pack[1] = v[1];
        if_reg.bru_execute_channel_feedback_pack[0] = v[2];
        if_reg.csr_execute_channel_feedback_pack[0] = v[3];
        if_reg.div_execute_channel_feedback_pack[0] = v[4];
        if_reg.lsu_execute_channel_feedback_pack[0] = v[5];
        if_reg.mul_execute_channel_feedback_pack[0] = v[6];
        if_reg.mul_execute_channel_feedback_pack[1] = v[7];
    endtask

    task automatic test_index_identity();
        ch_bits_t v[8];
        ch_bits_t got, e;
        for (int i = 0; i < 8; i++) begin
            v[i] = mk(1'b1, 6'(i + 8), 32'(i));
            exp_q.push_back(v[i]);
        end
        drive_comb(v);
        #10;
        for (int i = 0; i < 8; i++) begin
            got = if_comb.execute_feedback_pack[i];
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL identity ch%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_field_integrity();
        ch_bits_t v[8];
        ch_bits_t got, e;
        for (int i = 0; i < 8; i++) v[i] = '0;
        v[1] = mk(1'b1, 6'h2A, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
        drive_comb(v);
        #10;
        for (int i = 0; i < 8; i++) begin
            got = if_comb.execute_feedback_pack[i];
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL field_integrity ch%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_group_boundary();
        ch_bits_t v[8];
        ch_bits_t got, e;
        for (int i = 0; i < 8; i++) v[i] = rnd_ch();
        for (int step = 0; step < 2; step++) begin
            v[5][38] = (step == 1);
            for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
            drive_comb(v);
            #10;
            for (int i = 0; i < 8; i++) begin
                got = if_comb.execute_feedback_pack[i];
                e   = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL boundary step%0d ch%0d got=%h exp=%h", step, i, got, e);
                end
            end
        end
    endtask

    task automatic test_zero_count();
        int src[7] = '{0, 1, 2, 4, 5, 6, 7};
        ch_bits_t got, e;
        if_zero.alu_execute_channel_feedback_pack[0] = mk(1'b1, 6'd0, 32'd0);
        if_zero.alu_execute_channel_feedback_pack[1] = mk(1'b1, 6'd1, 32'd1);
        if_zero.bru_execute_channel_feedback_pack[0] = mk(1'b1, 6'd2, 32'd2);
        if_zero.csr_execute_channel_feedback_pack[0] = '0;
        if_zero.div_execute_channel_feedback_pack[0] = mk(1'b1, 6'd4, 32'd4);
        if_zero.lsu_execute_channel_feedback_pack[0] = mk(1'b1, 6'd5, 32'd5);
        if_zero.mul_execute_channel_feedback_pack[0] = mk(1'b1, 6'd6, 32'd6);
        if_zero.mul_execute_channel_feedback_pack[1] = mk(1'b1, 6'd7, 32'd7);
        for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b1, 6'(src[i]), 32'(src[i])));
        #10;
        for (int i = 0; i < 7; i++) begin
            got = if_zero.execute_feedback_pack[i];
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL zero_count ch%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_reset();
        ch_bits_t v[8];
        ch_bits_t got, e;
        for (int i = 0; i < 8; i++) v[i] = mk(1'b1, 6'(i + 8), 32'(i));
        @(negedge clk);
        rst = 1'b1;
        drive_reg(v);
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (cyc == 2) begin
                @(negedge clk);
                rst = 1'b0;
            end
            for (int i = 0; i < 8; i++) exp_q.push_back((cyc == 2) ? v[i] : '0);
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                got = if_reg.execute_feedback_pack[i];
                e   = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL reset cyc%0d ch%0d got=%h exp=%h", cyc, i, got, e);
                end
            end
        end
    endtask

    task automatic test_registered_stream();
        ch_bits_t v[8];
        ch_bits_t prev[8];
        ch_bits_t got, e;
        for (int i = 0; i < 8; i++) prev[i] = mk(1'b1, 6'(i + 8), 32'(i));
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) v[i] = rnd_ch();
            rst = (cyc == 5);
            drive_reg(v);
            #1;
            // Output must still hold the previous edge's capture before the next edge.
            for (int i = 0; i < 8; i++) begin
                got = if_reg.execute_feedback_pack[i];
                checks++;
                if (got !== prev[i]) begin
                    failures++;
                    $display("FAIL stream_hold cyc%0d ch%0d got=%h exp=%h", cyc, i, got, prev[i]);
                end
            end
            for (int i = 0; i < 8; i++) exp_q.push_back(rst ? '0 : v[i]);
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                got     = if_reg.execute_feedback_pack[i];
                e       = exp_q.pop_front();
                prev[i] = e;
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL stream cyc%0d ch%0d got=%h exp=%h", cyc, i, got, e);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        ch_bits_t z[8];
        for (int i = 0; i < 8; i++) z[i] = '0;
        drive_comb(z);
        drive_reg(z);
        test_index_identity();
        test_field_integrity();
        test_group_boundary();
        test_zero_count();
        test_reset();
        test_registered_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
